// File: rtl/fp_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fp_ctrl_pkg
// Shared types and constants for the FP issue/retire controller:
//   - state_e   : issue FSM states (IDLE, ISSUE, SERIAL)
//   - fp_tag_t  : FPU tag layout {is_int, rd}
//   - FFLAG_*   : bit positions of the IEEE exception flags {NV,DZ,OF,UF,NX}
//   - fflags_next : sticky flag update rule
// -----------------------------------------------------------------------------
package fp_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SERIAL = 2'd2
  } state_e;

  typedef struct packed {
    logic       is_int;
    logic [4:0] rd;
  } fp_tag_t;

  localparam int FFLAG_W  = 5;
  localparam int FFLAG_NX = 0;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_NV = 4;

  // A clear that coincides with a retire must not lose that retire's flags,
  // so the clear replaces the accumulated value with the new status.
  function automatic logic [FFLAG_W-1:0] fflags_next(
    input logic [FFLAG_W-1:0] cur,
    input logic [FFLAG_W-1:0] status,
    input logic               clr,
    input logic               retire
  );
    logic [FFLAG_W-1:0] res;
    res = cur;
    if (clr && retire) begin
      res = status;
    end else if (clr) begin
      res = '0;
    end else if (retire) begin
      res = cur | status;
    end
    return res;
  endfunction

endpackage

// File: rtl/fp_scoreboard.sv
// -----------------------------------------------------------------------------
// fp_scoreboard
// One pending-write bit per FP register plus the hazard compare for a
// candidate op (three sources + destination).
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   flush              clears every bit
//   set_en, set_addr   mark a register as having a write in flight
//   clr_en, clr_addr   release a register on retire
//   rs, rs_used        {rs3,rs2,rs1} source addresses and their valid bits
//   rd, rd_chk         destination and whether it needs a WAW check
//   hazard             candidate op conflicts with the registered scoreboard
// -----------------------------------------------------------------------------
module fp_scoreboard #(
  parameter int NUM_FREG = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush,
  input  logic        set_en,
  input  logic [4:0]  set_addr,
  input  logic        clr_en,
  input  logic [4:0]  clr_addr,
  input  logic [14:0] rs,
  input  logic [2:0]  rs_used,
  input  logic [4:0]  rd,
  input  logic        rd_chk,
  output logic        hazard
);

  logic [NUM_FREG-1:0] sb_q;
  logic [NUM_FREG-1:0] set_vec;
  logic [NUM_FREG-1:0] clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en) set_vec[set_addr] = 1'b1;
    if (clr_en) clr_vec[clr_addr] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sb_q <= '0;
    end else if (flush) begin
      sb_q <= '0;
    end else begin
      sb_q <= (sb_q & ~clr_vec) | set_vec;
    end
  end

  // Compare against the registered bits only: a retire in the same cycle
  // unblocks the dependent op one cycle later.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rs_used[i] && sb_q[rs[i*5 +: 5]]) hazard = 1'b1;
    end
    if (rd_chk && sb_q[rd]) hazard = 1'b1;
  end

endmodule

// File: rtl/fp_issue_ctrl.sv
// -----------------------------------------------------------------------------
// fp_issue_ctrl
// Issue/retire controller between the core decode stage and an fpnew_top FPU.
// Ports:
//   req_*            decoded FP op from the core (valid/ready handshake)
//   fpu_in_*/tag_o   FPU input handshake with {is_int, rd} tag
//   fpu_out_*/tag_i  FPU result handshake, status flags
//   flush_i          core flush; forwarded registered on fpu_flush_o
//   wb_*             FP / integer register-file write strobes and address
//   fflags_o         sticky IEEE exception flags, fflags_clr_i clears
//   busy_o           op held for issue or ops in flight
//   err_o            sticky: a result arrived with nothing outstanding
// -----------------------------------------------------------------------------
module fp_issue_ctrl
  import fp_ctrl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int NUM_FREG        = 32,
  parameter int TAG_W           = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [14:0]      req_rs_i,
  input  logic [2:0]       req_rs_used_i,
  input  logic [4:0]       req_rd_i,
  input  logic             req_rd_we_i,
  input  logic             req_rd_is_int_i,
  output logic             fpu_in_valid_o,
  input  logic             fpu_in_ready_i,
  output logic [TAG_W-1:0] fpu_tag_o,
  input  logic             fpu_out_valid_i,
  output logic             fpu_out_ready_o,
  input  logic [TAG_W-1:0] fpu_tag_i,
  input  logic [4:0]       fpu_status_i,
  input  logic             flush_i,
  output logic             fpu_flush_o,
  output logic             wb_fp_we_o,
  output logic             wb_int_we_o,
  output logic [4:0]       wb_addr_o,
  output logic [4:0]       fflags_o,
  input  logic             fflags_clr_i,
  output logic             busy_o,
  output logic             err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  state_e             state_q, state_d;
  fp_tag_t            hold_q;
  fp_tag_t            out_tag;
  logic [CNT_W-1:0]   count_q;
  logic [FFLAG_W-1:0] fflags_q;
  logic               err_q;
  logic               flush_q;
  logic               out_rdy_q;

  logic hazard;
  logic can_accept;
  logic accept;
  logic out_fire;
  logic retire;
  logic stray;

  assign out_tag = fp_tag_t'(fpu_tag_i);

  // Results presented during a flush cycle are dropped entirely.
  assign out_fire = fpu_out_valid_i && !flush_i;
  assign retire   = out_fire && (count_q != '0);
  assign stray    = out_fire && (count_q == '0);

  assign can_accept = (state_q == IDLE) && !hazard &&
                      (count_q < CNT_W'(MAX_OUTSTANDING)) && !flush_i;
  assign accept     = req_valid_i && can_accept;

  fp_scoreboard #(
    .NUM_FREG (NUM_FREG)
  ) u_sb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .flush    (flush_i),
    .set_en   (accept && req_rd_we_i && !req_rd_is_int_i),
    .set_addr (req_rd_i),
    .clr_en   (retire && !out_tag.is_int),
    .clr_addr (out_tag.rd),
    .rs       (req_rs_i),
    .rs_used  (req_rs_used_i),
    .rd       (req_rd_i),
    .rd_chk   (req_rd_we_i && !req_rd_is_int_i),
    .hazard   (hazard)
  );

  always_comb begin
    state_d        = state_q;
    fpu_in_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        fpu_in_valid_o = 1'b1;
        if (fpu_in_ready_i) state_d = hold_q.is_int ? SERIAL : IDLE;
      end
      SERIAL: begin
        // Integer-destination ops are serialised: wait for their result.
        if (retire && out_tag.is_int) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      count_q   <= '0;
      fflags_q  <= '0;
      err_q     <= 1'b0;
      flush_q   <= 1'b0;
      out_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flush_q   <= flush_i;
      out_rdy_q <= 1'b1;
      fflags_q  <= fflags_next(fflags_q, fpu_status_i, fflags_clr_i, retire);
      if (stray) err_q <= 1'b1;
      if (flush_i) begin
        hold_q  <= '0;
        count_q <= '0;
      end else begin
        if (accept) hold_q <= '{is_int: req_rd_is_int_i, rd: req_rd_i};
        case ({accept, retire})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  assign req_ready_o     = can_accept;
  assign fpu_tag_o       = TAG_W'(hold_q);
  assign fpu_out_ready_o = out_rdy_q;
  assign fpu_flush_o     = flush_q;
  assign wb_fp_we_o      = out_fire && !out_tag.is_int;
  assign wb_int_we_o     = out_fire && out_tag.is_int;
  assign wb_addr_o       = out_tag.rd;
  assign fflags_o        = fflags_q;
  assign err_o           = err_q;
  assign busy_o          = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_fp_issue_ctrl.sv
module tb_fp_issue_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [14:0] req_rs_i;
  logic [2:0]  req_rs_used_i;
  logic [4:0]  req_rd_i;
  logic        req_rd_we_i;
  logic        req_rd_is_int_i;
  logic        fpu_in_valid_o;
  logic        fpu_in_ready_i;
  logic [5:0]  fpu_tag_o;
  logic        fpu_out_valid_i;
  logic        fpu_out_ready_o;
  logic [5:0]  fpu_tag_i;
  logic [4:0]  fpu_status_i;
  logic        flush_i;
  logic        fpu_flush_o;
  logic        wb_fp_we_o;
  logic        wb_int_we_o;
  logic [4:0]  wb_addr_o;
  logic [4:0]  fflags_o;
  logic        fflags_clr_i;
  logic        busy_o;
  logic        err_o;

  int vecs = 0;
  int miss = 0;

  always #5 clk_i = ~clk_i;

  fp_issue_ctrl #(
    .MAX_OUTSTANDING (4),
    .NUM_FREG        (32),
    .TAG_W           (6)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_rs_i        (req_rs_i),
    .req_rs_used_i   (req_rs_used_i),
    .req_rd_i        (req_rd_i),
    .req_rd_we_i     (req_rd_we_i),
    .req_rd_is_int_i (req_rd_is_int_i),
    .fpu_in_valid_o  (fpu_in_valid_o),
    .fpu_in_ready_i  (fpu_in_ready_i),
    .fpu_tag_o       (fpu_tag_o),
    .fpu_out_valid_i (fpu_out_valid_i),
    .fpu_out_ready_o (fpu_out_ready_o),
    .fpu_tag_i       (fpu_tag_i),
    .fpu_status_i    (fpu_status_i),
    .flush_i         (flush_i),
    .fpu_flush_o     (fpu_flush_o),
    .wb_fp_we_o      (wb_fp_we_o),
    .wb_int_we_o     (wb_int_we_o),
    .wb_addr_o       (wb_addr_o),
    .fflags_o        (fflags_o),
    .fflags_clr_i    (fflags_clr_i),
    .busy_o          (busy_o),
    .err_o           (err_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_req(input logic v, input logic [4:0] rd, input logic is_int,
                           input logic [14:0] rs, input logic [2:0] used);
    req_valid_i     = v;
    req_rd_i        = rd;
    req_rd_we_i     = 1'b1;
    req_rd_is_int_i = is_int;
    req_rs_i        = rs;
    req_rs_used_i   = used;
  endtask

  task automatic drive_out(input logic v, input logic [5:0] tag, input logic [4:0] st);
    fpu_out_valid_i = v;
    fpu_tag_i       = tag;
    fpu_status_i    = st;
  endtask

  // Accept an independent FP op to f<rd> and let the FPU take it.
  task automatic issue_fp(input logic [4:0] rd);
    drive_req(1'b1, rd, 1'b0, 15'd0, 3'b000);
    step();
    step();
    drive_req(1'b0, 5'd0, 1'b0, 15'd0, 3'b000);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    drive_req(1'b0, 5'd0, 1'b0, 15'd0, 3'b000);
    drive_out(1'b0, 6'd0, 5'd0);
    fpu_in_ready_i = 1'b1;
    flush_i        = 1'b0;
    fflags_clr_i   = 1'b0;
    #2;
    vecs++; if (fpu_in_valid_o !== 1'b0) begin miss++; $display("FAIL rst_in_valid: got %b exp 0", fpu_in_valid_o); end
    vecs++; if (fpu_tag_o !== 6'h00) begin miss++; $display("FAIL rst_tag: got %h exp 00", fpu_tag_o); end
    vecs++; if (fflags_o !== 5'b0) begin miss++; $display("FAIL rst_fflags: got %b exp 00000", fflags_o); end
    vecs++; if (err_o !== 1'b0 || busy_o !== 1'b0 || fpu_flush_o !== 1'b0) begin
      miss++; $display("FAIL rst_err_busy_flush: got %b%b%b exp 000", err_o, busy_o, fpu_flush_o);
    end
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    step();
    vecs++; if (fpu_out_ready_o !== 1'b1) begin miss++; $display("FAIL out_ready: got %b exp 1", fpu_out_ready_o); end
    vecs++; if (req_ready_o !== 1'b1) begin miss++; $display("FAIL rst_req_ready: got %b exp 1", req_ready_o); end
  endtask

  task automatic test_back_to_back();
    drive_req(1'b1, 5'd1, 1'b0, 15'd0, 3'b000);
    #1;
    vecs++; if (req_ready_o !== 1'b1) begin miss++; $display("FAIL b2b_rdy_f1: got %b exp 1", req_ready_o); end
    step();
    drive_req(1'b1, 5'd2, 1'b0, 15'd0, 3'b000);
    #1;
    vecs++; if (fpu_in_valid_o !== 1'b1 || fpu_tag_o !== 6'h01) begin
      miss++; $display("FAIL b2b_issue_f1: got v=%b tag=%h exp v=1 tag=01", fpu_in_valid_o, fpu_tag_o);
    end
    vecs++; if (req_ready_o !== 1'b0) begin miss++; $display("FAIL b2b_rdy_in_issue: got %b exp 0", req_ready_o); end
    step();
    vecs++; if (req_ready_o !== 1'b1) begin miss++; $display("FAIL b2b_rdy_f2: got %b exp 1", req_ready_o); end
    step();
    drive_req(1'b0, 5'd0, 1'b0, 15'd0, 3'b000);
    #1;
    vecs++; if (fpu_in_valid_o !== 1'b1 || fpu_tag_o !== 6'h02) begin
      miss++; $display("FAIL b2b_issue_f2: got v=%b tag=%h exp v=1 tag=02", fpu_in_valid_o, fpu_tag_o);
    end
    step();
    drive_out(1'b1, 6'h01, 5'd0);
    #1;
    vecs++; if (wb_fp_we_o !== 1'b1 || wb_int_we_o !== 1'b0 || wb_addr_o !== 5'd1) begin
      miss++; $display("FAIL b2b_wb_f1: got fp=%b int=%b addr=%0d exp 1 0 1", wb_fp_we_o, wb_int_we_o, wb_addr_o);
    end
    step();
    drive_out(1'b1, 6'h02, 5'd0);
    #1;
    vecs++; if (wb_fp_we_o !== 1'b1 || wb_addr_o !== 5'd2) begin
      miss++; $display("FAIL b2b_wb_f2: got fp=%b addr=%0d exp 1 2", wb_fp_we_o, wb_addr_o);
    end
    vecs++; if (busy_o !== 1'b1) begin miss++; $display("FAIL b2b_busy_mid: got %b exp 1", busy_o); end
    step();
    drive_out(1'b0, 6'h00, 5'd0);
    #1;
    vecs++; if (busy_o !== 1'b0) begin miss++; $display("FAIL b2b_busy_end: got %b exp 0", busy_o); end
  endtask

  task automatic test_raw();
    drive_req(1'b1, 5'd5, 1'b0, 15'd0, 3'b000);
    step();
    drive_req(1'b1, 5'd6, 1'b0, 15'd5, 3'b001);
    step();
    vecs++; if (req_ready_o !== 1'b0) begin miss++; $display("FAIL raw_stall0: got %b exp 0", req_ready_o); end
    step();
    vecs++; if (req_ready_o !== 1'b0) begin miss++; $display("FAIL raw_stall1: got %b exp 0", req_ready_o); end
    drive_out(1'b1, 6'h05, 5'd0);
    #1;
    vecs++; if (req_ready_o !== 1'b0) begin miss++; $display("FAIL raw_same_cycle: got %b exp 0", req_ready_o); end
    step();
    drive_out(1'b0, 6'h00, 5'd0);
    #1;
    vecs++; if (req_ready_o !== 1'b1) begin miss++; $display("FAIL raw_release: got %b exp 1", req_ready_o); end
    step();
    drive_req(1'b0, 5'd0, 1'b0, 15'd0, 3'b000);
    #1;
    vecs++; if (fpu_in_valid_o !== 1'b1 || fpu_tag_o !== 6'h06) begin
      miss++; $display("FAIL raw_issue_f6: got v=%b tag=%h exp v=1 tag=06", fpu_in_valid_o, fpu_tag_o);
    end
    step();
    drive_out(1'b1, 6'h06, 5'd0);
    step();
    drive_out(1'b0, 6'h00, 5'd0);
  endtask

  task automatic test_serial();
    drive_req(1'b1, 5'd10, 1'b1, 15'd0, 3'b000);
    #1;
    vecs++; if (req_ready_o !== 1'b1) begin miss++; $display("FAIL ser_rdy: got %b exp 1", req_ready_o); end
    step();
    drive_req(1'b1, 5'd3, 1'b0, 15'd0, 3'b000);
    #1;
    vecs++; if (fpu_tag_o !== 6'h2a) begin miss++; $display("FAIL ser_tag: got %h exp 2a", fpu_tag_o); end
    step();
    vecs++; if (req_ready_o !== 1'b0 || busy_o !== 1'b1) begin
      miss++; $display("FAIL ser_stall0: got rdy=%b busy=%b exp 0 1", req_ready_o, busy_o);
    end
    step();
    vecs++; if (req_ready_o !== 1'b0) begin miss++; $display("FAIL ser_stall1: got %b exp 0", req_ready_o); end
    drive_out(1'b1, 6'h2a, 5'd0);
    #1;
    vecs++; if (wb_int_we_o !== 1'b1 || wb_fp_we_o !== 1'b0 || wb_addr_o !== 5'd10) begin
      miss++; $display("FAIL ser_wb: got int=%b fp=%b addr=%0d exp 1 0 10", wb_int_we_o, wb_fp_we_o, wb_addr_o);
    end
    step();
    drive_out(1'b0, 6'h00, 5'd0);
    #1;
    vecs++; if (req_ready_o !== 1'b1) begin miss++; $display("FAIL ser_release: got %b exp 1", req_ready_o); end
    step();
    drive_req(1'b0, 5'd0, 1'b0, 15'd0, 3'b000);
    step();
    drive_out(1'b1, 6'h03, 5'd0);
    step();
    drive_out(1'b0, 6'h00, 5'd0);
    #1;
    vecs++; if (busy_o !== 1'b0) begin miss++; $display("FAIL ser_busy_end: got %b exp 0", busy_o); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) begin
      drive_req(1'b1, 5'(i), 1'b0, 15'd0, 3'b000);
      step();
      step();
    end
    drive_req(1'b1, 5'd5, 1'b0, 15'd0, 3'b000);
    #1;
    vecs++; if (req_ready_o !== 1'b0) begin miss++; $display("FAIL fill_full: got %b exp 0", req_ready_o); end
    step();
    drive_out(1'b1, 6'h01, 5'd0);
    #1;
    vecs++; if (req_ready_o !== 1'b0) begin miss++; $display("FAIL fill_same_cycle: got %b exp 0", req_ready_o); end
    step();
    drive_out(1'b0, 6'h00, 5'd0);
    #1;
    vecs++; if (req_ready_o !== 1'b1) begin miss++; $display("FAIL fill_release: got %b exp 1", req_ready_o); end
    step();
    drive_req(1'b0, 5'd0, 1'b0, 15'd0, 3'b000);
    #1;
    vecs++; if (fpu_in_valid_o !== 1'b1 || fpu_tag_o !== 6'h05) begin
      miss++; $display("FAIL fill_issue_f5: got v=%b tag=%h exp v=1 tag=05", fpu_in_valid_o, fpu_tag_o);
    end
    step();
    for (int i = 2; i <= 5; i++) begin
      drive_out(1'b1, 6'(i), 5'd0);
      step();
    end
    drive_out(1'b0, 6'h00, 5'd0);
    #1;
    vecs++; if (busy_o !== 1'b0) begin miss++; $display("FAIL fill_busy_end: got %b exp 0", busy_o); end
  endtask

  task automatic test_fflags();
    issue_fp(5'd1);
    issue_fp(5'd2);
    drive_out(1'b1, 6'h01, 5'b00001);
    step();
    drive_out(1'b1, 6'h02, 5'b10000);
    step();
    drive_out(1'b0, 6'h00, 5'd0);
    #1;
    vecs++; if (fflags_o !== 5'b10001) begin miss++; $display("FAIL ff_accum: got %b exp 10001", fflags_o); end
    issue_fp(5'd3);
    fflags_clr_i = 1'b1;
    drive_out(1'b1, 6'h03, 5'b00100);
    step();
    fflags_clr_i = 1'b0;
    drive_out(1'b0, 6'h00, 5'd0);
    #1;
    vecs++; if (fflags_o !== 5'b00100) begin miss++; $display("FAIL ff_clr_retire: got %b exp 00100", fflags_o); end
    fflags_clr_i = 1'b1;
    step();
    fflags_clr_i = 1'b0;
    #1;
    vecs++; if (fflags_o !== 5'b00000) begin miss++; $display("FAIL ff_clr: got %b exp 00000", fflags_o); end
  endtask

  task automatic test_flush();
    issue_fp(5'd1);
    issue_fp(5'd2);
    issue_fp(5'd3);
    #1;
    vecs++; if (busy_o !== 1'b1) begin miss++; $display("FAIL fl_busy_pre: got %b exp 1", busy_o); end
    flush_i = 1'b1;
    drive_out(1'b1, 6'h02, 5'b01000);
    drive_req(1'b1, 5'd7, 1'b0, 15'd0, 3'b000);
    #1;
    vecs++; if (wb_fp_we_o !== 1'b0 || req_ready_o !== 1'b0) begin
      miss++; $display("FAIL fl_suppress: got wb=%b rdy=%b exp 0 0", wb_fp_we_o, req_ready_o);
    end
    step();
    flush_i = 1'b0;
    drive_out(1'b0, 6'h00, 5'd0);
    drive_req(1'b0, 5'd1, 1'b0, 15'd0, 3'b000);
    #1;
    vecs++; if (fpu_flush_o !== 1'b1 || busy_o !== 1'b0) begin
      miss++; $display("FAIL fl_pulse: got flush=%b busy=%b exp 1 0", fpu_flush_o, busy_o);
    end
    vecs++; if (req_ready_o !== 1'b1) begin miss++; $display("FAIL fl_sb_clear: got %b exp 1", req_ready_o); end
    vecs++; if (fflags_o !== 5'b0 || err_o !== 1'b0) begin
      miss++; $display("FAIL fl_flags_err: got ff=%b err=%b exp 00000 0", fflags_o, err_o);
    end
    step();
    vecs++; if (fpu_flush_o !== 1'b0) begin miss++; $display("FAIL fl_pulse_end: got %b exp 0", fpu_flush_o); end
    drive_out(1'b1, 6'h01, 5'b00010);
    step();
    drive_out(1'b0, 6'h00, 5'd0);
    #1;
    vecs++; if (err_o !== 1'b1) begin miss++; $display("FAIL fl_err: got %b exp 1", err_o); end
    vecs++; if (fflags_o !== 5'b0 || busy_o !== 1'b0) begin
      miss++; $display("FAIL fl_stray_ignored: got ff=%b busy=%b exp 00000 0", fflags_o, busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_raw();
    test_serial();
    test_fill();
    test_fflags();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/fp_issue_ctrl.md
Name: fp_issue_ctrl

Overview:
- Issue and retire controller for the fpnew_top-based FP datapath; sits between the core decode stage and the FPU.
- Accepts one decoded FP op per handshake and checks FP register hazards against a per-register scoreboard.
- Drives the FPU input handshake with a destination tag, and turns FPU results into FP/integer register-file write strobes.
- Accumulates sticky IEEE exception flags and handles pipeline flush.

Parameters:
MAX_OUTSTANDING, 4, max ops issued to FPU but not yet retired (2..8)
NUM_FREG, 32, FP register count (scoreboard depth)
TAG_W, 6, FPU tag width: {is_int_dest, rd[4:0]}

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  core presents decoded FP op
req_ready_o  out  1  op accepted this cycle when high with req_valid_i
req_rs_i  in  15  {rs3,rs2,rs1} FP source addresses
req_rs_used_i  in  3  per-source valid bits
req_rd_i  in  5  destination register
req_rd_we_i  in  1  op writes a destination
req_rd_is_int_i  in  1  destination is integer RF (compare/class/fcvt.w/fmv.x.w)
fpu_in_valid_o  out  1  to FPU in_valid_i
fpu_in_ready_i  in  1  from FPU in_ready_o
fpu_tag_o  out  TAG_W  to FPU tag_i
fpu_out_valid_i  in  1  from FPU out_valid_o
fpu_out_ready_o  out  1  to FPU out_ready_i
fpu_tag_i  in  TAG_W  from FPU tag_o
fpu_status_i  in  5  from FPU status_o {NV,DZ,OF,UF,NX}
flush_i  in  1  core pipeline flush
fpu_flush_o  out  1  to FPU flush_i
wb_fp_we_o  out  1  FP RF write strobe
wb_int_we_o  out  1  integer RF write strobe
wb_addr_o  out  5  write-back register
fflags_o  out  5  sticky exception flags
fflags_clr_i  in  1  CSR write clears fflags
busy_o  out  1  ops in flight or request held
err_o  out  1  sticky: retire with zero outstanding

Behaviour:
- Reset: FSM in IDLE; scoreboard and count cleared; fflags_o=0, err_o=0, fpu_in_valid_o=0, fpu_flush_o=0, fpu_tag_o=0, busy_o=0.
- FSM states:
  - IDLE: req_ready_o = !hazard && count<MAX_OUTSTANDING && !flush_i.
    - Hazard means a used rs with its scoreboard bit set, or an FP rd (we && !is_int) with its bit set (WAW).
    - On accept, the op is latched into the hold register and the FSM moves to ISSUE.
  - ISSUE: fpu_in_valid_o=1 with the latched tag; req_ready_o=0.
    - On fpu_in_ready_i, the FSM moves to SERIAL if is_int_dest, else to IDLE.
    - fpu_in_valid_o stays high until fpu_in_ready_i, with a stable tag.
  - SERIAL: an integer-destination op is in flight and no further accepts occur. The FSM returns to IDLE on its retire.
- Accept latency: fpu_in_valid_o rises the cycle after the accept. Sustained throughput is one op per 2 cycles.
- Scoreboard bit [rd] is set on accept when rd_we && !rd_is_int.
  - It is cleared on retire (fpu_out_valid_i with !tag[5]).
  - The hazard check uses the registered scoreboard, so a same-cycle retire does not unblock an accept until the next cycle.
- count increments on accept and decrements on retire; simultaneous accept and retire leave it unchanged.
  - A retire with count==0 is ignored and sets err_o.
- fpu_out_ready_o = 1 whenever out of reset.
- Write-back is combinational from the FPU output:
  - wb_fp_we_o = out_valid && !tag[5].
  - wb_int_we_o = out_valid && tag[5].
  - wb_addr_o = tag[4:0].
- fflags: each retire ORs fpu_status_i into fflags.
  - fflags_clr_i alone clears fflags.
  - Simultaneous clr and retire loads fpu_status_i.
- Flush:
  - flush_i pulses fpu_flush_o for one cycle (registered).
  - On the same edge, the scoreboard, count and hold register clear and the FSM forces IDLE.
  - Results with fpu_out_valid_i during that flush cycle are suppressed (no wb strobes, no fflags update).
- busy_o = (state!=IDLE) || count!=0.

Decomposition:
- Shared package fp_ctrl_pkg holds:
  - state enum {IDLE, ISSUE, SERIAL}
  - tag struct {is_int, rd}
  - fflag bit-index constants
- One sub-module fp_scoreboard: NUM_FREG-bit set/clear/flush vector plus a 3-source + rd hazard compare.

Test Plan:
- Back-to-back independent fadd.s to f1 then f2, FPU latency 3 → accepts at cycles 0 and 2; wb_fp_we_o with addr 1 then 2; count peaks at 2.
- RAW hazard: fmul.s to f5, then fadd.s reading f5 → req_ready_o=0 until the cycle after f5 retires; the second op then issues.
- feq.s to x10 (is_int) → FSM stays in SERIAL; a following op is stalled until wb_int_we_o=1 with addr 10.
- Fill: hold fpu_out_valid_i low and issue to f1..f4 with MAX=4 → the fifth request stalls; one retire → the fifth is accepted the next cycle.
- fflags: retire with status 5'b00001, then 5'b10000 → fflags_o=5'b10001; clr with a concurrent retire of 5'b00100 → 5'b00100.
- Flush with 3 ops in flight, plus a spurious retire afterwards → fpu_flush_o pulses once, busy_o=0 the next cycle, and err_o=1.
